// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; XLEN-cycle latency, start ignored while busy.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after accept.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN-1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t          state_q;
   logic            rem_op_q;
   logic            neg_quo_q;
   logic            neg_rem_q;
   logic            dz_q;
   logic            ovf_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvsr_q;
   logic [XLEN-1:0] dvnd_q;
   logic [CW-1:0]   count_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] result_q;

   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            acc_dz;
   logic            acc_ovf;

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic            ge;
   logic [XLEN-1:0] rem_d;
   logic [XLEN-1:0] quo_d;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   function automatic logic [XLEN-1:0] forced_res(input logic rem_op,
                                                  input logic [XLEN-1:0] dvnd,
                                                  input logic dz);
      logic [XLEN-1:0] r;
      if (dz) r = rem_op ? dvnd : '1;
      else    r = rem_op ? '0 : MIN_NEG;
      return r;
   endfunction

   always_comb begin
      a_neg   = ~op_i[0] & rs1_data_i[XLEN-1];
      b_neg   = ~op_i[0] & rs2_data_i[XLEN-1];
      a_mag   = a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
      b_mag   = b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
      acc_dz  = (rs2_data_i == '0);
      acc_ovf = ~op_i[0] & (rs1_data_i == MIN_NEG) & (rs2_data_i == '1);
   end

   // Borrow out of the XLEN+1-bit subtract is the "rem < divisor" flag.
   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvsr_q};
      ge      = ~diff[XLEN];
      rem_d   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_d   = {quo_q[XLEN-2:0], ge};
      quo_fix = neg_quo_q ? (~quo_d + 1'b1) : quo_d;
      rem_fix = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rem_op_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         dvnd_q    <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (count_q == '0) begin
                  if (dz_q | ovf_q) result_q <= forced_res(rem_op_q, dvnd_q, dz_q);
                  else              result_q <= rem_op_q ? rem_fix : quo_fix;
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
            default: begin
               if (start_i) begin
                  rem_op_q  <= op_i[1];
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  dz_q      <= acc_dz;
                  ovf_q     <= acc_ovf;
                  rem_q     <= '0;
                  quo_q     <= a_mag;
                  dvsr_q    <= b_mag;
                  dvnd_q    <= rs1_data_i;
                  count_q   <= CNT_INIT;
`ifdef DIV_EARLY_OUT_EN
                  if (acc_dz | acc_ovf) begin
                     result_q <= forced_res(op_i[1], rs1_data_i, acc_dz);
                     state_q  <= S_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                  end
`else
                  state_q <= S_CALC;
                  busy_q  <= 1'b1;
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule
